ysyx_22040632_mem_arb: RTL
==========================

// Module: ysyx_22040632_mem_arb
// PURPOSE
//  Arbitrates one 64-bit physical-memory port between instruction fetch (IF, read-only) and the load/store unit (LS, read/write).
//  Sits between the IFU/LSU and the memory model/bus adapter.
//  One transaction in flight at a time; round-robin on contention.
//  A watchdog turns a hung memory access into an error response.
//  The IF response is dropped when the fetch is flushed by a PC redirect.
// PARAMETERS
//  AW          64  address width
//  DW          64  data width (byte mask width DW/8)
//  TIMEOUT_CYC 256 max cycles in WAIT before error response; 0 = watchdog disabled
// PORTS
//  clk            in   1      clock
//  rrst_n         in   1      reset, asynchronous, active-low
//  if_req_valid   in   1      IF read request
//  if_req_ready   out  1      IF request accepted this cycle when valid&ready
//  if_addr        in   AW     IF fetch address (8-byte aligned line)
//  if_flush       in   1      PC redirect: kill pending/in-flight IF response
//  if_resp_valid  out  1      one-cycle IF response pulse
//  if_rdata       out  DW     IF read data
//  if_resp_err    out  1      IF response is a timeout error
//  ls_req_valid   in   1      LS request
//  ls_req_ready   out  1      LS request accepted when valid&ready
//  ls_addr        in   AW     LS address
//  ls_wen         in   1      1=write, 0=read
//  ls_wdata       in   DW     LS write data
//  ls_wmask       in   DW/8   LS byte write mask
//  ls_resp_valid  out  1      one-cycle LS response pulse
//  ls_rdata       out  DW     LS read data (0 for writes)
//  ls_resp_err    out  1      LS response is a timeout error
//  mem_req_valid  out  1      downstream request valid
//  mem_req_ready  in   1      downstream accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  AW/1/DW/DW/8  latched request fields
//  mem_resp_valid in   1      downstream response (one cycle)
//  mem_rdata      in   DW     downstream read data
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; data outputs 0; rr_last=LS (first tie goes to IF); drop=0; wdog=0.
//  States: IDLE -> REQ -> WAIT -> RESP -> IDLE. owner bit (IF/LS) is latched at accept.
//  IDLE:
//   - grant is combinational: only IF valid -> IF; only LS valid -> LS; both -> the one not equal to rr_last.
//   - x_req_ready=1 only for the granted requester, only in IDLE.
//   - if_req_ready is forced 0 while if_flush=1; in that case LS may be granted instead.
//   - On accept: latch addr/wen/wdata/wmask (IF: wen=0, wmask=0), set owner, rr_last=owner, go to REQ.
//  REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1; then go to WAIT and clear wdog.
//   - Request accepted at cycle N -> mem_req_valid first high at N+1.
//  WAIT:
//   - wdog increments each cycle.
//   - mem_resp_valid=1 -> capture mem_rdata (forced to 0 if wen), err=0, go to RESP.
//   - TIMEOUT_CYC!=0 and wdog==TIMEOUT_CYC-1 with no response -> rdata=0, err=1, go to RESP.
//  RESP:
//   - owner's x_resp_valid=1 for exactly one cycle; go to IDLE.
//   - Mem response at cycle M -> resp pulse at M+1 -> new accept possible at M+2.
//   - If owner=IF and drop=1: if_resp_valid stays 0; drop clears on leaving RESP.
//  Flush:
//   - if_flush=1 while owner=IF in REQ/WAIT/RESP sets drop.
//   - The memory transaction itself still completes normally; no abort downstream.
//   - if_flush in IDLE has no effect on LS.
//  Late responses: mem_resp_valid outside WAIT is ignored (e.g. arriving after a timeout).
//  mem_req_ready outside REQ is ignored.
//  Responses have no back-pressure; requesters must take the pulse.
//  x_rdata/x_resp_err hold their value until the next response for that requester.
//  Reset asserted mid-transaction returns to IDLE immediately; no response is emitted.
// TESTING
//  1. IF-only read addr 0x8000_0000; mem ready at once, resp after 3 cyc with 0x00000013_00100093
//     -> if_resp_valid 1 cycle, if_rdata matches, ls_resp_valid stays 0.
//  2. IF and LS valid together from reset -> IF granted first, then LS; repeat both valid -> IF, LS, IF, LS alternate.
//  3. LS write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F -> mem_wen=1 and fields stable through REQ;
//     ls_rdata=0, ls_resp_err=0.
//  4. IF read in flight, pulse if_flush in WAIT -> mem response consumed, no if_resp_valid; next IF fetch completes normally.
//  5. TIMEOUT_CYC=8, mem never responds -> ls_resp_valid with ls_resp_err=1 8 cycles after REQ handshake;
//     a late mem_resp_valid is ignored.
//  6. mem_req_ready held low 5 cycles -> mem_req_valid/addr stable; rrst_n low in WAIT -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/ysyx_22040632_mem_arb.sv
// rtl/ysyx_22040632_mem_arb.sv - round-robin IF/LS arbiter for one memory port with watchdog and IF flush drop
module ysyx_22040632_mem_arb #(
    parameter int AW          = 64,
    parameter int DW          = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            clk,
    input  logic            rrst_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_resp_err,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [AW-1:0]   ls_addr,
    input  logic            ls_wen,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wmask,
    output logic            ls_resp_valid,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state, state_nx;
    logic        owner_ls;
    logic        rr_last_ls;
    logic        drop;
    logic [31:0] wdog;

    logic          if_ok, grant_if, grant_ls, accept, timeout_hit, wait_done;
    logic [DW-1:0] resp_data;
    logic          resp_err;

    // A flushing IF requester is masked so LS can win the port that cycle
    always_comb begin
        if_ok    = if_req_valid && !if_flush;
        grant_ls = ls_req_valid && (!if_ok || !rr_last_ls);
        grant_if = if_ok && !grant_ls;
    end

    assign if_req_ready  = rrst_n && (state == S_IDLE) && grant_if;
    assign ls_req_ready  = rrst_n && (state == S_IDLE) && grant_ls;
    assign accept        = if_req_ready || ls_req_ready;
    assign mem_req_valid = (state == S_REQ);
    assign ls_resp_valid = (state == S_RESP) && owner_ls;
    assign if_resp_valid = (state == S_RESP) && !owner_ls && !drop && !if_flush;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (wdog == 32'(TIMEOUT_CYC - 1));
    assign wait_done   = mem_resp_valid || timeout_hit;
    assign resp_data   = (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
    assign resp_err    = !mem_resp_valid;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)        state_nx = S_REQ;
            S_REQ:   if (mem_req_ready) state_nx = S_WAIT;
            S_WAIT:  if (wait_done)     state_nx = S_RESP;
            S_RESP:                     state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= S_IDLE;
            owner_ls    <= 1'b0;
            rr_last_ls  <= 1'b1;
            drop        <= 1'b0;
            wdog        <= '0;
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            if_rdata    <= '0;
            if_resp_err <= 1'b0;
            ls_rdata    <= '0;
            ls_resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (accept) begin
                    owner_ls   <= grant_ls;
                    rr_last_ls <= grant_ls;
                    mem_addr   <= grant_ls ? ls_addr : if_addr;
                    mem_wen    <= grant_ls && ls_wen;
                    mem_wdata  <= grant_ls ? ls_wdata : '0;
                    mem_wmask  <= grant_ls ? ls_wmask : '0;
                end
                S_REQ: if (mem_req_ready) wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog + 32'd1;
                    if (wait_done) begin
                        if (owner_ls) begin
                            ls_rdata    <= resp_data;
                            ls_resp_err <= resp_err;
                        end else if (!drop && !if_flush) begin
                            if_rdata    <= resp_data;
                            if_resp_err <= resp_err;
                        end
                    end
                end
                default: ;
            endcase
            // Drop outlives the flush pulse until the killed response slot passes
            if (state == S_RESP)
                drop <= 1'b0;
            else if (state != S_IDLE && !owner_ls && if_flush)
                drop <= 1'b1;
        end
    end

endmodule
